// File: rtl/deemph_iir.sv
// First-order IIR de-emphasis filter: y[n] = deq(B0*x[n]) + deq(B1*x[n-1]) + deq(A1*y[n-1]).
// Optional macro DEEMPH_SAT_EN clamps each result to the 16-bit audio range.
module deemph_iir #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int B0         = 178,
    parameter int B1         = 178,
    parameter int A1         = -667
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] C_RND = PW'((1 << BITS) - 1);

    typedef enum logic [1:0] {S_READ, S_MUL, S_SUM, S_WRITE} state_t;

    state_t                         r_state;
    logic signed [DATA_WIDTH-1:0]   r_x;
    logic signed [DATA_WIDTH-1:0]   r_x_prev;
    logic signed [DATA_WIDTH-1:0]   r_y_prev;
    logic        [DATA_WIDTH-1:0]   r_out_din;
    logic signed [PW-1:0]           r_prod [3];

    logic signed [PW-1:0]           w_coef [3];
    logic signed [PW-1:0]           w_op   [3];
    logic signed [PW-1:0]           w_deq  [3];
    logic signed [PW-1:0]           w_sum;
    logic        [DATA_WIDTH-1:0]   w_result;

    assign w_coef[0] = PW'(B0);
    assign w_coef[1] = PW'(B1);
    assign w_coef[2] = PW'(A1);
    assign w_op[0]   = PW'(r_x);
    assign w_op[1]   = PW'(r_x_prev);
    assign w_op[2]   = PW'(r_y_prev);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_prod[gi] <= '0;
                end else if (r_state == S_MUL) begin
                    r_prod[gi] <= w_coef[gi] * w_op[gi];
                end
            end

            // Bias negative products so the arithmetic shift truncates toward zero.
            assign w_deq[gi] = (r_prod[gi][PW-1] ? (r_prod[gi] + C_RND) : r_prod[gi]) >>> BITS;
        end
    endgenerate

    assign w_sum = w_deq[0] + w_deq[1] + w_deq[2];

`ifdef DEEMPH_SAT_EN
    localparam logic signed [PW-1:0] C_MAX = PW'(32767);
    localparam logic signed [PW-1:0] C_MIN = PW'(-32768);
    logic signed [PW-1:0] w_clamped;

    always_comb begin
        w_clamped = w_sum;
        if (w_sum > C_MAX) begin
            w_clamped = C_MAX;
        end else if (w_sum < C_MIN) begin
            w_clamped = C_MIN;
        end
    end

    logic w_unused_clamp_hi;
    assign w_unused_clamp_hi = ^w_clamped[PW-1:DATA_WIDTH];
    assign w_result          = w_clamped[DATA_WIDTH-1:0];
`else
    logic w_unused_sum_hi;
    assign w_unused_sum_hi = ^w_sum[PW-1:DATA_WIDTH];
    assign w_result        = w_sum[DATA_WIDTH-1:0];
`endif

    assign in_rd_en  = !reset && (r_state == S_READ)  && !in_empty;
    assign out_wr_en = !reset && (r_state == S_WRITE) && !out_full;
    assign out_din   = r_out_din;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_READ;
            r_x       <= '0;
            r_x_prev  <= '0;
            r_y_prev  <= '0;
            r_out_din <= '0;
        end else begin
            case (r_state)
                S_READ: begin
                    if (in_rd_en) begin
                        r_x     <= in_dout;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    r_out_din <= w_result;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    // History advances only on an accepted push.
                    if (out_wr_en) begin
                        r_x_prev <= r_x;
                        r_y_prev <= r_out_din;
                        r_state  <= S_READ;
                    end
                end
                default: begin
                    r_state <= S_READ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_deemph_iir.sv
// Randomized and directed bench for deemph_iir against a plain-arithmetic filter model.
module tb_deemph_iir;
    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        in_empty = 1'b1;
    logic [31:0] in_dout  = '0;
    logic        out_full = 1'b0;
    logic        in_rd_en;
    logic        out_wr_en;
    logic [31:0] out_din;

    deemph_iir dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
    );

    always #5 clock = ~clock;

    int     checks = 0;
    int     errors = 0;
    int     n_writes = 0;
    int     in_q[$];
    longint exp_q[$];
    int     got_q[$];
    longint m_xp = 0;
    longint m_yp = 0;

    logic        m_pop  = 1'b0;
    logic        m_push = 1'b0;
    logic        m_rst  = 1'b0;
    logic [31:0] m_data = '0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // C-model arithmetic: signed integer division truncates toward zero.
    function automatic longint model_step(input int x);
        longint y;
        y = (178 * longint'(x)) / 1024 + (178 * m_xp) / 1024 + (-667 * m_yp) / 1024;
`ifdef DEEMPH_SAT_EN
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
`else
        y = longint'(int'(y));
`endif
        m_xp = x;
        m_yp = y;
        return y;
    endfunction

    always @(posedge clock) begin
        m_pop  <= in_rd_en;
        m_push <= out_wr_en;
        m_rst  <= reset;
        m_data <= out_din;
    end

    // Upstream FIFO, downstream sink and scoreboard, updated between edges.
    always @(negedge clock) begin
        if (m_rst) begin
            m_xp = 0;
            m_yp = 0;
            exp_q.delete();
        end
        check("rd_wr_exclusive", m_pop && m_push, 0);
        if (m_pop) begin
            if (in_q.size() == 0) begin
                check("pop_from_empty", 1, 0);
            end else begin
                exp_q.push_back(model_step(in_q.pop_front()));
            end
        end
        if (m_push) begin
            n_writes++;
            got_q.push_back(int'(m_data));
            $display("[%0t] write #%0d out_din=%0d", $time, n_writes, $signed(m_data));
            if (exp_q.size() == 0) begin
                check("spurious_write", 1, 0);
            end else begin
                check("stream_data", $signed(m_data), exp_q.pop_front());
            end
        end
        in_empty = (in_q.size() == 0);
        in_dout  = (in_q.size() > 0) ? in_q[0] : 0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        check("reset_rd_en", in_rd_en, 0);
        check("reset_wr_en", out_wr_en, 0);
        reset = 1'b0;
        tick(1);
        check("reset_out_din", $signed(out_din), 0);
    endtask

    task automatic wait_outputs(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_outputs_timeout", got_q.size() >= n, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        int c;

        // Step response; a sample queued during reset must not be popped early.
        got_q.delete();
        repeat (3) in_q.push_back(1024);
        do_reset();
        wait_outputs(3, 100);
        check("step_y0", got_q[0], 178);
        check("step_y1", got_q[1], 241);
        check("step_y2", got_q[2], 200);

        // Truncation toward zero on small negative products.
        do_reset();
        got_q.delete();
        in_q.push_back(-1);
        in_q.push_back(0);
        wait_outputs(2, 100);
        check("trunc_y0", got_q[0], 0);
        check("trunc_y1", got_q[1], 0);

        // Backpressure: held output, no pops, then same results as unstalled.
        do_reset();
        got_q.delete();
        out_full = 1'b1;
        repeat (3) in_q.push_back(1024);
        tick(5);
        held = out_din;
        check("bp_held_value", $signed(held), 178);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("bp_wr_en", out_wr_en, 0);
            check("bp_rd_en", in_rd_en, 0);
            check("bp_out_stable", $signed(out_din), $signed(held));
        end
        out_full = 1'b0;
        wait_outputs(3, 100);
        check("bp_y0", got_q[0], 178);
        check("bp_y1", got_q[1], 241);
        check("bp_y2", got_q[2], 200);

        // Reset while the sample sits in S_SUM.
        do_reset();
        got_q.delete();
        in_q.push_back(1024);
        c = 0;
        while (in_q.size() != 0 && c < 50) begin
            tick(1);
            c++;
        end
        check("midrst_pop_timeout", in_q.size(), 0);
        reset = 1'b1;
        tick(1);
        check("midrst_wr_en", out_wr_en, 0);
        reset = 1'b0;
        in_q.push_back(1024);
        wait_outputs(1, 100);
        tick(10);
        check("midrst_count", got_q.size(), 1);
        check("midrst_y0", got_q[0], 178);

        // Large input: clamp or wrap-free 32-bit result.
        do_reset();
        got_q.delete();
        in_q.push_back(500000);
        wait_outputs(1, 100);
`ifdef DEEMPH_SAT_EN
        check("big_input", got_q[0], 32767);
`else
        check("big_input", got_q[0], 86914);
`endif

        // Random stream with random backpressure and gaps.
        do_reset();
        got_q.delete();
        n_writes = 0;
        for (int i = 0; i < 256; i++) begin
            in_q.push_back(int'($urandom_range(0, 65535)) - 32768);
            out_full = ($urandom_range(0, 9) < 3);
            tick($urandom_range(0, 4));
        end
        out_full = 1'b0;
        wait_outputs(256, 5000);
        tick(10);
        check("stream_writes", n_writes, 256);
        check("stream_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
